// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared floor sizing, debounce default and floor typedefs
package elevator_pkg;

  localparam int N_FLOORS         = 8;
  localparam int FLOOR_W          = 3;
  localparam int DEBOUNCE_DEFAULT = 50000;

  typedef logic [N_FLOORS-1:0] floor_vec_t;
  typedef logic [FLOOR_W-1:0]  floor_idx_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, stable-count debouncer and rise detector for one button
module btn_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             s;
  logic             db;
  logic             db_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      s       <= 1'b0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      s       <= sync1;
      db_prev <= db;
      // Any sample agreeing with the current level restarts qualification.
      if (s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = db;
  assign rise  = db & ~db_prev;

endmodule

// File: rtl/elevator_req_latch.sv
// rtl/elevator_req_latch.sv - debounced hall/car/door button front end latching floor requests
// Optional car-call cancel on re-press of a pending floor: macro REQ_CANCEL_EN.
module elevator_req_latch #(
  parameter int N_FLOORS        = elevator_pkg::N_FLOORS,
  parameter int DEBOUNCE_CYCLES = elevator_pkg::DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_FLOORS-1:0]       out_req,
  input  logic [N_FLOORS-1:0]       in_req,
  input  logic                      open_door_bnt,
  input  logic                      close_door_bnt,
  input  logic                      serve_valid,
  input  elevator_pkg::floor_idx_t  serve_floor,
  output logic [N_FLOORS-1:0]       floor_req,
  output logic                      req_pending,
  output logic                      open_door_sig,
  output logic                      close_door_sig
);
  import elevator_pkg::*;

  localparam int N_BTN = 2 * N_FLOORS + 2;

  // Channel order: hall calls, car calls, open, close.
  logic [N_BTN-1:0]    btn_raw;
  logic [N_BTN-1:0]    btn_level;
  logic [N_BTN-1:0]    btn_rise;
  logic [N_FLOORS-1:0] out_rise;
  logic [N_FLOORS-1:0] in_rise;
  logic                open_rise;
  logic                close_rise;
  logic [N_FLOORS-1:0] serve_clr;
  logic [N_FLOORS-1:0] cancel;
  logic [N_FLOORS-1:0] floor_nxt;
  logic                unused_levels;

  assign btn_raw = {close_door_bnt, open_door_bnt, in_req, out_req};

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_btn (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[g]),
      .level (btn_level[g]),
      .rise  (btn_rise[g])
    );
  end

  assign out_rise      = btn_rise[N_FLOORS-1:0];
  assign in_rise       = btn_rise[2*N_FLOORS-1:N_FLOORS];
  assign open_rise     = btn_rise[2*N_FLOORS];
  assign close_rise    = btn_rise[2*N_FLOORS+1];
  assign unused_levels = ^btn_level;

  // Served floor decode; indices the floor bus cannot express never match.
  always_comb begin
    serve_clr = '0;
    if (serve_valid) begin
      for (int i = 0; i < N_FLOORS; i++) begin
        if (i < (1 << FLOOR_W) && serve_floor == floor_idx_t'(i)) begin
          serve_clr[i] = 1'b1;
        end
      end
    end
  end

`ifdef REQ_CANCEL_EN
  assign cancel = in_rise & floor_req & ~out_rise;
`else
  assign cancel = '0;
`endif

  // Serve clear beats everything, cancel beats a set, otherwise hold.
  assign floor_nxt = (floor_req | out_rise | in_rise) & ~cancel & ~serve_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      floor_req      <= '0;
      open_door_sig  <= 1'b0;
      close_door_sig <= 1'b0;
    end else begin
      floor_req      <= floor_nxt;
      open_door_sig  <= open_rise;
      close_door_sig <= close_rise & ~open_rise;
    end
  end

  assign req_pending = |floor_req;

endmodule
